// File: rtl/spi_eeprom_pkg.sv
// Shared constants and FSM encoding for the SPI EEPROM boot loader.
package spi_eeprom_pkg;

    localparam logic [7:0]  SPI_READ_OP = 8'h03;
    localparam int unsigned CMD_BITS    = 8;
    localparam int unsigned ADDR_BITS   = 16;
    localparam int unsigned HDR_BITS    = CMD_BITS + ADDR_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

endpackage

// File: rtl/spi_eeprom_loader_bit_engine.sv
// SPI mode-0 clock divider with single-bit MOSI launch and MISO capture.
module spi_bit_engine #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic toggle_en,
    input  logic load,
    input  logic tx_bit,
    input  logic miso,
    output logic spi_clk_out,
    output logic mosi_out,
    output logic rx_bit,
    output logic wrap_c,
    output logic rise_tick_c,
    output logic fall_tick_c
);

    localparam int unsigned     DIV_W    = 8;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    // Half-period boundary; the clock only toggles when the FSM is shifting.
    assign wrap_c      = run && (div_cnt == DIV_LAST);
    assign rise_tick_c = wrap_c && toggle_en && !spi_clk_out;
    assign fall_tick_c = wrap_c && toggle_en && spi_clk_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt     <= '0;
            spi_clk_out <= 1'b0;
            mosi_out    <= 1'b0;
            rx_bit      <= 1'b0;
        end else begin
            if (!run || wrap_c) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end

            if (!run) begin
                spi_clk_out <= 1'b0;
            end else if (rise_tick_c) begin
                spi_clk_out <= 1'b1;
            end else if (fall_tick_c) begin
                spi_clk_out <= 1'b0;
            end

            // MOSI only moves together with the falling edge, never while high.
            if (load || fall_tick_c) begin
                mosi_out <= tx_bit;
            end else if (!run) begin
                mosi_out <= 1'b0;
            end

            if (rise_tick_c) begin
                rx_bit <= miso;
            end
        end
    end

endmodule

// File: rtl/spi_eeprom_loader.sv
// Issues one EEPROM READ per start request and streams the returned bytes
// into a register-file write port.
module spi_eeprom_loader
    import spi_eeprom_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned CS_GAP  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [15:0]      rom_addr,
    input  logic [LEN_W-1:0] byte_count,
    output logic             busy,
    output logic             done,
    output logic             spi_clk_out,
    output logic             mosi_out,
    output logic             spi_en_out,
    input  logic             miso,
    output logic             wr_en,
    output logic [LEN_W-1:0] wr_addr,
    output logic [7:0]       wr_data
);

    localparam int unsigned BIT_W = $clog2(HDR_BITS + 8 * ((1 << LEN_W) - 1) + 1);
    localparam int unsigned GAP_W = $clog2(CS_GAP + 1);
    localparam int unsigned SR_W  = HDR_BITS - 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

    state_t           state, state_d;
    logic [SR_W-1:0]  cmd_sr, cmd_sr_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [BIT_W-1:0] bit_cnt, bit_cnt_d, last_bit_c;
    logic [6:0]       rx_sr, rx_sr_d;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_d;
    logic             rx_pend;
    logic             done_d, wr_en_d, active_d;
    logic [LEN_W-1:0] wr_addr_d;
    logic [7:0]       wr_data_d;
    logic             run_c, toggle_en_c, load_c, tx_bit_c;
    logic             wrap_c, rise_tick_c, fall_tick_c, rx_bit;

    spi_bit_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_engine (
        .clk         (clk),
        .reset       (reset),
        .run         (run_c),
        .toggle_en   (toggle_en_c),
        .load        (load_c),
        .tx_bit      (tx_bit_c),
        .miso        (miso),
        .spi_clk_out (spi_clk_out),
        .mosi_out    (mosi_out),
        .rx_bit      (rx_bit),
        .wrap_c      (wrap_c),
        .rise_tick_c (rise_tick_c),
        .fall_tick_c (fall_tick_c)
    );

    // Index of the final bit: 24 header bits plus 8 per data byte.
    assign last_bit_c = BIT_W'(HDR_BITS - 1) + (BIT_W'(count_q) << 3);
    assign tx_bit_c   = (state == S_IDLE) ? SPI_READ_OP[CMD_BITS-1] : cmd_sr[SR_W-1];

    always_comb begin
        state_d     = state;
        cmd_sr_d    = cmd_sr;
        count_d     = count_q;
        bit_cnt_d   = bit_cnt;
        rx_sr_d     = rx_sr;
        gap_cnt_d   = gap_cnt;
        done_d      = 1'b0;
        wr_en_d     = 1'b0;
        wr_data_d   = wr_data;
        wr_addr_d   = wr_en ? wr_addr + LEN_W'(1) : wr_addr;
        run_c       = 1'b0;
        toggle_en_c = 1'b0;
        load_c      = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (byte_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = S_SETUP;
                        cmd_sr_d  = {SPI_READ_OP[CMD_BITS-2:0], rom_addr};
                        count_d   = byte_count;
                        bit_cnt_d = '0;
                        wr_addr_d = '0;
                        load_c    = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                run_c = 1'b1;
                if (wrap_c) begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                run_c       = 1'b1;
                toggle_en_c = 1'b1;
                if (fall_tick_c) begin
                    if (bit_cnt == last_bit_c) begin
                        state_d = S_HOLD;
                    end else begin
                        bit_cnt_d = bit_cnt + BIT_W'(1);
                        cmd_sr_d  = {cmd_sr[SR_W-2:0], 1'b0};
                    end
                end
            end
            S_HOLD: begin
                run_c = 1'b1;
                if (wrap_c) begin
                    state_d   = S_GAP;
                    done_d    = 1'b1;
                    gap_cnt_d = '0;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt + GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Byte assembly: data bits start after the header, 8 bits per byte.
        if (rx_pend && (bit_cnt >= BIT_W'(HDR_BITS))) begin
            rx_sr_d = {rx_sr[5:0], rx_bit};
            if (bit_cnt[2:0] == 3'd7) begin
                wr_en_d   = 1'b1;
                wr_data_d = {rx_sr, rx_bit};
            end
        end

        active_d = (state_d == S_SETUP) || (state_d == S_SHIFT) || (state_d == S_HOLD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cmd_sr     <= '0;
            count_q    <= '0;
            bit_cnt    <= '0;
            rx_sr      <= '0;
            gap_cnt    <= '0;
            rx_pend    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            spi_en_out <= 1'b1;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            state      <= state_d;
            cmd_sr     <= cmd_sr_d;
            count_q    <= count_d;
            bit_cnt    <= bit_cnt_d;
            rx_sr      <= rx_sr_d;
            gap_cnt    <= gap_cnt_d;
            rx_pend    <= rise_tick_c;
            busy       <= active_d;
            done       <= done_d;
            spi_en_out <= !active_d;
            wr_en      <= wr_en_d;
            wr_addr    <= wr_addr_d;
            wr_data    <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_spi_eeprom_loader.sv
// Directed bench for spi_eeprom_loader with a behavioural M95xxx model.
module tb_spi_eeprom_loader;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned LEN_W   = 8;
    localparam int unsigned CS_GAP  = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [15:0]      rom_addr = 16'h0000;
    logic [LEN_W-1:0] byte_count = '0;
    logic             busy, done, spi_clk_out, mosi_out, spi_en_out, wr_en;
    logic             miso = 1'b0;
    logic [LEN_W-1:0] wr_addr;
    logic [7:0]       wr_data;

    int n_checks = 0;
    int n_fail   = 0;

    spi_eeprom_loader #(
        .CLK_DIV (CLK_DIV),
        .LEN_W   (LEN_W),
        .CS_GAP  (CS_GAP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .rom_addr    (rom_addr),
        .byte_count  (byte_count),
        .busy        (busy),
        .done        (done),
        .spi_clk_out (spi_clk_out),
        .mosi_out    (mosi_out),
        .spi_en_out  (spi_en_out),
        .miso        (miso),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] rom_byte(input logic [15:0] a);
        case (a)
            16'h0000: rom_byte = 8'hDE;
            16'h0001: rom_byte = 8'hAD;
            16'h0002: rom_byte = 8'hBE;
            16'h0003: rom_byte = 8'hEF;
            16'h1234: rom_byte = 8'h5A;
            default:  rom_byte = 8'hFF;
        endcase
    endfunction

    // EEPROM model and bus monitor, sampled on the falling clk edge.
    int          m_bits = 0;
    logic [23:0] m_hdr = '0, m_last_hdr = '0;
    logic [15:0] m_addr = '0;
    logic [7:0]  m_byte = '0;
    logic        m_sclk_q = 1'b0, mosi_q = 1'b0, en_q = 1'b1, wren_q = 1'b0;
    int          rises_total = 0, en_toggles = 0, sclk_toggles = 0, wren_toggles = 0;
    int          done_total = 0, mode0_viol = 0, cs_cyc = 0, cs_min = 1000;
    bit          first_pend = 1'b1;
    logic [LEN_W-1:0] wq_addr[$];
    logic [7:0]       wq_data[$];

    always @(negedge clk) begin
        if (spi_clk_out !== m_sclk_q) sclk_toggles++;
        if (spi_en_out !== en_q) en_toggles++;
        if (wr_en !== wren_q) wren_toggles++;
        if (done === 1'b1) done_total++;
        if (wr_en === 1'b1) begin
            wq_addr.push_back(wr_addr);
            wq_data.push_back(wr_data);
        end
        if (spi_clk_out === 1'b1 && mosi_out !== mosi_q) mode0_viol++;
        if (spi_en_out === 1'b1) begin
            m_bits     = 0;
            cs_cyc     = 0;
            first_pend = 1'b1;
        end else if (spi_en_out === 1'b0) begin
            if (spi_clk_out === 1'b1 && m_sclk_q === 1'b0) begin
                rises_total++;
                if (first_pend) begin
                    if (cs_cyc < cs_min) cs_min = cs_cyc;
                    first_pend = 1'b0;
                end
                if (m_bits < 24) begin
                    m_hdr = {m_hdr[22:0], mosi_out};
                    if (m_bits == 23) m_last_hdr = m_hdr;
                end
                m_bits++;
            end else if (spi_clk_out === 1'b0 && m_sclk_q === 1'b1 && m_bits >= 24) begin
                if (((m_bits - 24) % 8) == 0) begin
                    m_addr = (m_bits == 24) ? m_hdr[15:0] : m_addr + 16'd1;
                    m_byte = rom_byte(m_addr);
                end
                miso   = m_byte[7];
                m_byte = {m_byte[6:0], 1'b0};
            end
            cs_cyc++;
        end
        m_sclk_q = spi_clk_out;
        mosi_q   = mosi_out;
        en_q     = spi_en_out;
        wren_q   = wr_en;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [15:0] a, input logic [LEN_W-1:0] n);
        rom_addr   = a;
        byte_count = n;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // cyc = clk edges since the edge after which start was raised.
    task automatic wait_done(input int limit, output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < limit) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({busy, done, wr_en} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctrl: busy/done/wr_en=%b want 000", {busy, done, wr_en});
        end
        n_checks++;
        if ({spi_clk_out, mosi_out, spi_en_out} !== 3'b001) begin
            n_fail++; $display("FAIL reset_spi: sclk/mosi/en=%b want 001", {spi_clk_out, mosi_out, spi_en_out});
        end
        n_checks++;
        if (wr_addr !== '0 || wr_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_wport: addr=%0h data=%0h want 0 0", wr_addr, wr_data);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_read4();
        int cyc;
        int w0;
        logic [7:0] exp [4];
        exp = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        repeat (CS_GAP + 2) tick();
        w0 = wq_addr.size();
        pulse_start(16'h0000, 8'd4);
        n_checks++;
        if (busy !== 1'b1 || spi_en_out !== 1'b0) begin
            n_fail++; $display("FAIL read4_accept: busy=%b en=%b want 1 0", busy, spi_en_out);
        end
        wait_done(2000, cyc);
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++; $display("FAIL read4_timeout: done=%b want 1", done);
        end
        n_checks++;
        if (cyc != 457) begin
            n_fail++; $display("FAIL read4_latency: got %0d cycles want 457", cyc);
        end
        n_checks++;
        if (busy !== 1'b0 || spi_en_out !== 1'b1) begin
            n_fail++; $display("FAIL read4_done_state: busy=%b en=%b want 0 1", busy, spi_en_out);
        end
        n_checks++;
        if (m_last_hdr !== 24'h030000) begin
            n_fail++; $display("FAIL read4_header: got %h want 030000", m_last_hdr);
        end
        n_checks++;
        if (wq_addr.size() - w0 != 4) begin
            n_fail++; $display("FAIL read4_nwrites: got %0d want 4", wq_addr.size() - w0);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ((w0 + i) >= wq_addr.size() || wq_addr[w0 + i] !== LEN_W'(i) || wq_data[w0 + i] !== exp[i]) begin
                n_fail++; $display("FAIL read4_write%0d: got addr=%0h data=%h want addr=%0h data=%h",
                                   i, wq_addr[w0 + i], wq_data[w0 + i], i, exp[i]);
            end
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || spi_en_out !== 1'b1) begin
            n_fail++; $display("FAIL read4_after_done: done=%b en=%b want 0 1", done, spi_en_out);
        end
    endtask

    task automatic test_read1();
        int cyc;
        int w0;
        int r0;
        repeat (CS_GAP + 2) tick();
        w0 = wq_addr.size();
        r0 = rises_total;
        pulse_start(16'h1234, 8'd1);
        wait_done(2000, cyc);
        n_checks++;
        if (done !== 1'b1 || cyc != 265) begin
            n_fail++; $display("FAIL read1_latency: done=%b cycles=%0d want 1 265", done, cyc);
        end
        n_checks++;
        if (m_last_hdr !== 24'h031234) begin
            n_fail++; $display("FAIL read1_header: got %h want 031234", m_last_hdr);
        end
        n_checks++;
        if (rises_total - r0 != 32) begin
            n_fail++; $display("FAIL read1_rises: got %0d want 32", rises_total - r0);
        end
        n_checks++;
        if (wq_addr.size() - w0 != 1 || wq_addr[w0] !== '0 || wq_data[w0] !== 8'h5A) begin
            n_fail++; $display("FAIL read1_write: n=%0d addr=%0h data=%h want 1 0 5a",
                               wq_addr.size() - w0, wq_addr[w0], wq_data[w0]);
        end
    endtask

    task automatic test_zero();
        int e0, s0, w0, d0;
        repeat (CS_GAP + 2) tick();
        e0 = en_toggles; s0 = sclk_toggles; w0 = wren_toggles; d0 = done_total;
        pulse_start(16'h0000, 8'd0);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL zero_done: done=%b busy=%b want 1 0", done, busy);
        end
        tick();
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL zero_pulse: done=%b want 0", done);
        end
        repeat (20) tick();
        n_checks++;
        if (en_toggles != e0 || sclk_toggles != s0 || wren_toggles != w0) begin
            n_fail++; $display("FAIL zero_quiet: toggles en=%0d sclk=%0d wr_en=%0d want 0 0 0",
                               en_toggles - e0, sclk_toggles - s0, wren_toggles - w0);
        end
        n_checks++;
        if (done_total - d0 != 1) begin
            n_fail++; $display("FAIL zero_ndone: got %0d want 1", done_total - d0);
        end
    endtask

    task automatic test_ignored();
        int cyc;
        int w0, d0;
        logic [7:0] exp [4];
        exp = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        repeat (CS_GAP + 2) tick();
        w0 = wq_addr.size();
        d0 = done_total;
        pulse_start(16'h0000, 8'd4);
        repeat (100) tick();
        pulse_start(16'h1234, 8'd1);
        wait_done(2000, cyc);
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++; $display("FAIL ignored_timeout: done=%b want 1", done);
        end
        pulse_start(16'h1234, 8'd1);
        repeat (20) tick();
        n_checks++;
        if (spi_en_out !== 1'b1 || busy !== 1'b0 || done_total - d0 != 1) begin
            n_fail++; $display("FAIL ignored_idle: en=%b busy=%b ndone=%0d want 1 0 1",
                               spi_en_out, busy, done_total - d0);
        end
        n_checks++;
        if (wq_addr.size() - w0 != 4) begin
            n_fail++; $display("FAIL ignored_nwrites: got %0d want 4", wq_addr.size() - w0);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ((w0 + i) >= wq_addr.size() || wq_addr[w0 + i] !== LEN_W'(i) || wq_data[w0 + i] !== exp[i]) begin
                n_fail++; $display("FAIL ignored_write%0d: got addr=%0h data=%h want addr=%0h data=%h",
                                   i, wq_addr[w0 + i], wq_data[w0 + i], i, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int hi;
        int w0;
        repeat (CS_GAP + 2) tick();
        pulse_start(16'h1234, 8'd1);
        wait_done(2000, cyc);
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++; $display("FAIL b2b_first_timeout: done=%b want 1", done);
        end
        w0 = wq_addr.size();
        rom_addr   = 16'h1234;
        byte_count = 8'd1;
        start      = 1'b1;
        hi = 0;
        while (spi_en_out === 1'b1 && hi < 50) begin
            hi++;
            tick();
        end
        start = 1'b0;
        n_checks++;
        if (spi_en_out !== 1'b0) begin
            n_fail++; $display("FAIL b2b_accept: en=%b want 0 within 50 cycles", spi_en_out);
        end
        n_checks++;
        if (hi < CS_GAP) begin
            n_fail++; $display("FAIL b2b_gap: cs high %0d cycles want >= %0d", hi, CS_GAP);
        end
        wait_done(2000, cyc);
        n_checks++;
        if (done !== 1'b1 || wq_addr.size() - w0 != 1 || wq_data[w0] !== 8'h5A) begin
            n_fail++; $display("FAIL b2b_second: done=%b n=%0d data=%h want 1 1 5a",
                               done, wq_addr.size() - w0, wq_data[w0]);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int w0, w1, d0;
        logic [7:0] exp [4];
        exp = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        repeat (CS_GAP + 2) tick();
        w0 = wq_addr.size();
        d0 = done_total;
        pulse_start(16'h0000, 8'd4);
        cyc = 0;
        while (wq_addr.size() == w0 && cyc < 2000) begin
            tick();
            cyc++;
        end
        n_checks++;
        if (wq_addr.size() != w0 + 1) begin
            n_fail++; $display("FAIL rstmid_first_byte: got %0d writes want 1", wq_addr.size() - w0);
        end
        repeat (20) tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if (spi_en_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || wr_en !== 1'b0 || spi_clk_out !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_outputs: en=%b busy=%b done=%b wr_en=%b sclk=%b want 1 0 0 0 0",
                               spi_en_out, busy, done, wr_en, spi_clk_out);
        end
        reset = 1'b0;
        w1 = wq_addr.size();
        repeat (600) tick();
        n_checks++;
        if (wq_addr.size() != w1 || done_total != d0) begin
            n_fail++; $display("FAIL rstmid_quiet: writes=%0d dones=%0d want 0 0",
                               wq_addr.size() - w1, done_total - d0);
        end
        pulse_start(16'h0000, 8'd4);
        wait_done(2000, cyc);
        n_checks++;
        if (done !== 1'b1 || cyc != 457) begin
            n_fail++; $display("FAIL rstmid_reread: done=%b cycles=%0d want 1 457", done, cyc);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ((w1 + i) >= wq_addr.size() || wq_addr[w1 + i] !== LEN_W'(i) || wq_data[w1 + i] !== exp[i]) begin
                n_fail++; $display("FAIL rstmid_write%0d: got addr=%0h data=%h want addr=%0h data=%h",
                                   i, wq_addr[w1 + i], wq_data[w1 + i], i, exp[i]);
            end
        end
    endtask

    task automatic test_mode0();
        repeat (CS_GAP + 2) tick();
        n_checks++;
        if (mode0_viol != 0) begin
            n_fail++; $display("FAIL mode0_mosi: %0d changes while sclk high want 0", mode0_viol);
        end
        n_checks++;
        if (cs_min < CLK_DIV || cs_min == 1000) begin
            n_fail++; $display("FAIL mode0_cs_lead: min cs-to-rise %0d cycles want >= %0d", cs_min, CLK_DIV);
        end
    endtask

    initial begin
        test_reset();
        test_read4();
        test_read1();
        test_zero();
        test_ignored();
        test_back_to_back();
        test_reset_mid();
        test_mode0();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
